// File: rtl/load_unit_pkg.sv
// Shared load-unit definitions: funct3 load encodings, FSM state type, legality helper.
// Latency: none (package only).
// Backpressure: n/a.
package load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    REQ_LO = 3'd2,
    REQ_HI = 3'd3,
    DONE   = 3'd4,
    FAULT  = 3'd5
  } load_state_e;

  // LD/LWU only exist on a 64-bit datapath; 3'b111 is never a load.
  function automatic logic funct3_legal(input logic [2:0] f3, input int xlen);
    logic ok;
    case (f3)
      F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ok = 1'b1;
      F3_LD, F3_LWU:                       ok = (xlen == 64);
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_unit_if.sv
// Memory read port of the load unit: request/address out, ack/data back.
// Latency: memory may ack in the same cycle as mem_req or any number of cycles later.
// Backpressure: requester holds mem_req and mem_addr until mem_ack.
interface load_unit_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/load_unit_extend.sv
// Lane selection and sign/zero extension of a load from a two-word window.
// Latency: combinational.
// Backpressure: none.
module load_extend
  import load_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]              lo,
  input  logic [XLEN-1:0]              hi,
  input  logic [$clog2(XLEN/8)-1:0]    byte_off,
  input  logic [2:0]                   funct3,
  output logic [XLEN-1:0]              result
);

  logic [2*XLEN-1:0] pair;
  logic [2*XLEN-1:0] shifted;

  // Little-endian: the addressed byte is moved to lane 0, upper lanes come from the next word.
  always_comb begin
    pair    = {hi, lo};
    shifted = pair >> {byte_off, 3'b000};
    result  = '0;
    case (funct3[1:0])
      2'b00:   result = funct3[2] ? XLEN'(shifted[7:0])  : XLEN'($signed(shifted[7:0]));
      2'b01:   result = funct3[2] ? XLEN'(shifted[15:0]) : XLEN'($signed(shifted[15:0]));
      2'b10:   result = funct3[2] ? XLEN'(shifted[31:0]) : XLEN'($signed(shifted[31:0]));
      default: result = shifted[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: computes ea, fetches one or two aligned words, returns the extended lane.
// Latency: done 3 cycles after the start edge for one word at zero wait, 4 when split.
// Backpressure: mem_req/mem_addr held until mem_ack; ACK_TIMEOUT cycles without ack faults.
// Option MISALIGNED_LOAD_TRAP_EN: misaligned loads fault in ADDR instead of being split.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] base,
  input  logic [XLEN-1:0] offset,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            fault,
  load_unit_if.master     mem
);

  localparam int WB   = XLEN / 8;
  localparam int OFFW = $clog2(WB);
  localparam int TW   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(ACK_TIMEOUT - 1);

  load_state_e     state;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] ea_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] hi_q;
  logic [TW-1:0]   wait_q;

  logic [3:0]      off4;
  logic [3:0]      size;
  logic            trap;
  logic            split;
  logic [XLEN-1:0] ext;

  assign off4 = 4'(ea_q[OFFW-1:0]);
  assign size = 4'd1 << f3_q[1:0];

`ifdef MISALIGNED_LOAD_TRAP_EN
  assign trap  = |(off4 & (size - 4'd1));
  assign split = 1'b0;
`else
  assign trap  = 1'b0;
  assign split = ({1'b0, off4} + {1'b0, size}) > 5'(WB);
`endif

  load_extend #(.XLEN(XLEN)) u_extend (
    .lo       (lo_q),
    .hi       (hi_q),
    .byte_off (ea_q[OFFW-1:0]),
    .funct3   (f3_q),
    .result   (ext)
  );

  // Load sequencer: all outputs registered; done/fault are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      f3_q         <= '0;
      ea_q         <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      wait_q       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      rdata        <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
    end else begin
      done  <= 1'b0;
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            f3_q  <= funct3;
            ea_q  <= base + offset;
            busy  <= 1'b1;
            state <= ADDR;
          end
        end
        ADDR: begin
          if (!funct3_legal(f3_q, XLEN) || trap) begin
            state <= FAULT;
          end else begin
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= {ea_q[XLEN-1:OFFW], {OFFW{1'b0}}};
            wait_q       <= '0;
            state        <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (mem.mem_ack) begin
            lo_q <= mem.mem_rdata;
            if (split) begin
              // Second beat; the address wraps to 0 past the top of memory.
              mem.mem_addr <= mem.mem_addr + XLEN'(WB);
              wait_q       <= '0;
              state        <= REQ_HI;
            end else begin
              mem.mem_req <= 1'b0;
              state       <= DONE;
            end
          end else if (wait_q == WAIT_LAST) begin
            mem.mem_req <= 1'b0;
            state       <= FAULT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        REQ_HI: begin
          if (mem.mem_ack) begin
            hi_q        <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            state       <= DONE;
          end else if (wait_q == WAIT_LAST) begin
            mem.mem_req <= 1'b0;
            state       <= FAULT;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        DONE: begin
          rdata <= ext;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          fault <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy        <= 1'b0;
          mem.mem_req <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Directed bench for load_unit with a small behavioural memory and configurable ack delay.
// Latency: measured in clock edges from the start edge.
// Backpressure: ack delay and a forced stray ack are driven from the bench.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] base;
  logic [31:0] offset;
  logic        busy;
  logic        done;
  logic        fault;
  logic [31:0] rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_delay = 0;
  int age = 0;
  logic force_ack = 1'b0;

  load_unit_if #(.XLEN(32)) mem_if ();

  load_unit #(.XLEN(32), .ACK_TIMEOUT(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .base   (base),
    .offset (offset),
    .busy   (busy),
    .done   (done),
    .rdata  (rdata),
    .fault  (fault),
    .mem    (mem_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_00a8: return 32'hdeadbeef;
      32'h0000_00ac: return 32'hcafebabe;
      32'h0000_0000: return 32'h11223344;
      32'hffff_fffc: return 32'h8899aabb;
      default:       return 32'h0;
    endcase
  endfunction

  assign mem_if.mem_rdata = mem_word(mem_if.mem_addr);
  assign mem_if.mem_ack   = (mem_if.mem_req && (age >= ack_delay)) || force_ack;

  always @(posedge clk) age <= (mem_if.mem_req && !mem_if.mem_ack) ? age + 1 : 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one load and observe it until done/fault (lat = edges after the start edge, 0 = none).
  task automatic do_load(input logic [2:0] f3, input logic [31:0] b, input logic [31:0] o,
                         input bit hold, output int lat, output int reqc, output bit flt,
                         output int nb, output logic [31:0] a0, output logic [31:0] a1,
                         output bit stable, output bit bsy1);
    logic [31:0] paddr;
    bit preq;
    bit pack;
    lat = 0; reqc = 0; flt = 0; nb = 0; a0 = '0; a1 = '0; stable = 1; bsy1 = 0;
    paddr = '0; preq = 0; pack = 0;
    @(negedge clk);
    funct3 = f3; base = b; offset = o; start = 1'b1;
    @(negedge clk);
    if (hold) begin
      funct3 = 3'b000; base = '0; offset = '0;
    end else begin
      start = 1'b0;
    end
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) bsy1 = busy;
      if (mem_if.mem_req) begin
        reqc++;
        if (preq && !pack && mem_if.mem_addr !== paddr) stable = 0;
        if (mem_if.mem_ack) begin
          if (nb == 0) a0 = mem_if.mem_addr; else a1 = mem_if.mem_addr;
          nb++;
        end
      end
      preq = mem_if.mem_req; pack = mem_if.mem_ack; paddr = mem_if.mem_addr;
      if (done || fault) begin
        lat = i; flt = fault;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, reqc, nb;
    bit flt, stable, bsy1;
    logic [31:0] a0, a1;

    reset = 1'b1; start = 1'b0; funct3 = '0; base = '0; offset = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_fault", fault, 0);
    check("rst_req",   mem_if.mem_req, 0);
    check("rst_addr",  mem_if.mem_addr, 0);
    check("rst_rdata", rdata, 0);
    reset = 1'b0;

    // LW aligned, zero wait
    do_load(3'b010, 32'ha8, 32'h0, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("lw_lat", lat, 3);
    check("lw_data", rdata, 32'hdeadbeef);
    check("lw_addr", a0, 32'ha8);
    check("lw_beats", nb, 1);
    check("lw_busy", bsy1, 1);

    do_load(3'b000, 32'ha8, 32'h1, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("lb_data", rdata, 32'hffffffbe);
    do_load(3'b100, 32'ha8, 32'h1, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("lbu_data", rdata, 32'h000000be);
    do_load(3'b001, 32'ha8, 32'h2, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("lh_data", rdata, 32'hffffdead);
    do_load(3'b101, 32'ha8, 32'h2, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("lhu_data", rdata, 32'h0000dead);
    do_load(3'b000, 32'hac, 32'hffffffff, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("lb_negoff", rdata, 32'hffffffde);
    do_load(3'b010, 32'hfffffffc, 32'h4, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("ea_wrap_addr", a0, 32'h0);
    check("ea_wrap_data", rdata, 32'h11223344);

    // Misaligned word / half, and split that wraps to address 0
    do_load(3'b010, 32'ha8, 32'h2, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
`ifdef MISALIGNED_LOAD_TRAP_EN
    check("mis_lw_fault", flt, 1);
    check("mis_lw_noreq", reqc, 0);
`else
    check("split_lat", lat, 4);
    check("split_beats", nb, 2);
    check("split_a0", a0, 32'ha8);
    check("split_a1", a1, 32'hac);
    check("split_data", rdata, 32'hbabedead);
`endif
    do_load(3'b001, 32'ha8, 32'h3, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
`ifdef MISALIGNED_LOAD_TRAP_EN
    check("mis_lh_fault", flt, 1);
`else
    check("split_lh_data", rdata, 32'hffffbede);
`endif
    do_load(3'b010, 32'hfffffffe, 32'h0, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
`ifdef MISALIGNED_LOAD_TRAP_EN
    check("mis_wrap_fault", flt, 1);
`else
    check("wrap_split_a0", a0, 32'hfffffffc);
    check("wrap_split_a1", a1, 32'h0);
    check("wrap_split_data", rdata, 32'h33448899);
`endif

    // Illegal encodings on a 32-bit unit
    do_load(3'b011, 32'ha8, 32'h0, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("ld_fault", flt, 1);
    check("ld_lat", lat, 2);
    check("ld_noreq", reqc, 0);
    do_load(3'b111, 32'ha8, 32'h0, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("f3_111_fault", flt, 1);

    // Ack delayed 3 cycles, start held high while busy
    ack_delay = 3;
    do_load(3'b010, 32'ha8, 32'h0, 1, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("slow_reqc", reqc, 4);
    check("slow_stable", stable, 1);
    check("slow_lat", lat, 6);
    check("slow_data", rdata, 32'hdeadbeef);
    check("slow_nofault", flt, 0);

    // No ack at all
    ack_delay = 1000;
    do_load(3'b010, 32'ha8, 32'h0, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("to_fault", flt, 1);
    check("to_reqc", reqc, 16);
    check("to_lat", lat, 18);
    check("to_req_low", mem_if.mem_req, 0);

    // Reset while waiting in REQ_LO, then a stray ack
    @(negedge clk);
    funct3 = 3'b010; base = 32'ha8; offset = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("mid_req_high", mem_if.mem_req, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req", mem_if.mem_req, 0);
    check("mid_rst_rdata", rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    check("stray_busy", busy, 0);
    check("stray_done", done, 0);
    @(negedge clk);
    check("stray_idle", busy, 0);
    ack_delay = 0;
    do_load(3'b010, 32'ha8, 32'h0, 0, lat, reqc, flt, nb, a0, a1, stable, bsy1);
    check("post_rst_lat", lat, 3);
    check("post_rst_data", rdata, 32'hdeadbeef);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_unit.md
LOAD_UNIT -- requirements
Module: load_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width; legal values 32 or 64.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, maximum cycles mem_req waits for mem_ack before fault.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  load request, sampled only in IDLE.
REQ-006 SHALL have port funct3  input  3  load type: LB 000, LH 001, LW 010, LD 011 (XLEN=64 only), LBU 100, LHU 101, LWU 110 (XLEN=64 only).
REQ-007 SHALL have port base  input  XLEN  rs1 value.
REQ-008 SHALL have port offset  input  XLEN  sign-extended immediate.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse; rdata valid.
REQ-011 SHALL have port rdata  output  XLEN  extended load result, held until the next done.
REQ-012 SHALL have port fault  output  1  one-cycle pulse; load aborted, no done.
REQ-013 SHALL have port mem_req  output  1  memory read request.
REQ-014 SHALL have port mem_addr  output  XLEN  XLEN/8-byte-aligned read address.
REQ-015 SHALL have port mem_ack  input  1  read data valid this cycle.
REQ-016 SHALL have port mem_rdata  input  XLEN  little-endian read word.

Function
REQ-017 SHALL implement FSM states IDLE, ADDR, REQ_LO, REQ_HI, DONE, FAULT.
REQ-018 IDLE with start=1 SHALL latch funct3, compute ea = base + offset (mod 2^XLEN), and go to ADDR; start while busy SHALL be ignored.
REQ-019 ADDR SHALL go to FAULT on illegal funct3, else to REQ_LO with mem_addr = ea with low log2(XLEN/8) bits cleared.
REQ-020 REQ_* SHALL hold mem_req=1 and mem_addr stable until the edge where mem_ack=1; mem_rdata SHALL be captured on that edge.
REQ-021 REQ_LO SHALL go to REQ_HI (mem_addr += XLEN/8) if the access spans two words, else to DONE; REQ_HI SHALL go to DONE.
REQ-022 DONE SHALL assert done for exactly one cycle, drive rdata, and return to IDLE; FAULT SHALL likewise pulse fault and return to IDLE.
REQ-023 With zero-wait memory (mem_ack same cycle as mem_req), done SHALL rise 3 cycles after the start edge for single-word access, 4 for split.
REQ-024 Byte selection SHALL be little-endian by ea offset; LB/LH/LW SHALL sign-extend, LBU/LHU/LWU SHALL zero-extend to XLEN.
REQ-025 A REQ state exceeding ACK_TIMEOUT cycles without mem_ack SHALL deassert mem_req and go to FAULT.
REQ-026 ea wrap-around past 2^XLEN-1 SHALL wrap silently; a split second beat SHALL wrap to address 0.

Reset
REQ-027 reset SHALL force IDLE immediately, including mid-transaction, and clear busy, done, fault, mem_req, mem_addr, rdata to 0; an in-flight mem_ack after reset SHALL be ignored.

Configuration
REQ-028 With MISALIGNED_LOAD_TRAP_EN defined, an access where ea is not aligned to its size SHALL go from ADDR to FAULT with no mem_req.
REQ-029 Without MISALIGNED_LOAD_TRAP_EN, misaligned accesses SHALL be serviced by the two-beat REQ_LO/REQ_HI split; REQ_HI SHALL be unreachable when the macro is defined.

Structure
REQ-030 Load funct3 encodings and the FSM state enum typedef SHALL live in the shared riscv package.
REQ-031 Byte/half/word lane selection and extension SHALL be a combinational sub-module load_extend.

Verification
REQ-032 LW base=0xa8 off=0, M[0xa8]=0xdeadbeef, zero wait -> mem_addr=0xa8, done 3 cycles after start, rdata=0xdeadbeef.
REQ-033 LB base=0xa8 off=1 -> rdata=0xffffffbe; LBU same -> 0x000000be; LH off=2 -> 0xffffdead.
REQ-034 LW base=0xa8 off=2, M[0xac]=0xcafebabe: macro off -> beats 0xa8,0xac, rdata=0xbabedead at cycle 4; macro on -> fault pulse, no mem_req.
REQ-035 LW with mem_ack delayed 3 cycles -> mem_req/mem_addr stable 4 cycles, done at cycle 6; no ack for ACK_TIMEOUT=16 cycles -> fault, mem_req low.
REQ-036 reset asserted during REQ_LO -> busy/mem_req low immediately, late mem_ack ignored, next LW completes normally.
